move_unpacker: RTL
==================

MOVE_UNPACKER -- requirements
Module: move_unpacker

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; no other clock or reset exists.
REQ-002 clk  in  1  system clock; all state changes on the rising edge.
REQ-003 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-004 start  in  1  one-cycle pulse, sampled in IDLE only; begins draining the move-generator FIFO.
REQ-005 fifoOut  in  160  FIFO word: slot1=[151:133], slot2=[132:114], ..., slot8=[18:0]; bits [159:152] ignored.
REQ-006 fifoEmpty  in  1  high when the move-generator FIFO holds no words.
REQ-007 rden  out  1  FIFO read strobe; the word appears on fifoOut one cycle after rden is sampled high.
REQ-008 mv_out  out  19  current move; [18] invalid flag (always 0 when mv_valid=1), [11:6] from-square, [5:0] to-square.
REQ-009 mv_valid  out  1  mv_out holds a valid move.
REQ-010 mv_ready  in  1  consumer accepts mv_out on a cycle where mv_valid and mv_ready are both 1.
REQ-011 mv_count  out  8  number of moves accepted since the last start.
REQ-012 done  out  1  high when the FIFO has been drained and every valid move has been accepted.

Function
REQ-013 States SHALL be IDLE, REQ, WAIT, SCAN and FIN.
REQ-014 IDLE: on start=1, clear mv_count and done, then go to REQ.
REQ-015 REQ: if fifoEmpty=1, go to FIN; otherwise drive rden=1 for exactly this cycle and go to WAIT.
REQ-016 WAIT: on the next edge, capture fifoOut into a 160-bit holding register, set the slot index to 1, and go to SCAN.
REQ-017 SCAN SHALL examine one slot per cycle, in order slot1 to slot8.
REQ-018 SCAN, invalid slot ([18]=1): mv_valid=0; advance the index in one cycle.
REQ-019 SCAN, valid slot ([18]=0): present the slot on mv_out with mv_valid=1; hold mv_out and mv_valid stable until mv_ready=1; then advance the index.
REQ-020 After slot8 is disposed of, return to REQ; the index wraps from 8 back to 1 only through REQ and WAIT.
REQ-021 Each accepted move SHALL increment mv_count by 1; mv_count saturates at 255.
REQ-022 FIN: done=1, mv_valid=0 and rden=0; stay in FIN until start=1, which behaves as in IDLE.
REQ-023 rden SHALL never be high in any state other than REQ, and never on two consecutive cycles.
REQ-024 Latency: a word whose slot1 is valid yields mv_valid=1 two cycles after its rden cycle.
REQ-025 A start pulse seen outside IDLE or FIN SHALL be ignored.
REQ-026 A word with all eight slots invalid SHALL take 8 SCAN cycles and produce no mv_valid.

Reset
REQ-027 While reset=1, the state SHALL be IDLE and rden=0, mv_valid=0, mv_out=0, mv_count=0, done=0, the holding register=0 and the index=1.
REQ-028 Reset asserted mid-operation SHALL abort the scan without further rden; any word already read is discarded.

Structure
REQ-029 A shared package chess_mv_pkg SHALL hold:
- slot width (19) and slot count (8);
- field offsets: invalid bit 18, from-square [11:6], to-square [5:0];
- the FSM state encoding.
REQ-030 Slot extraction SHALL be a combinational sub-module mv_slot_sel (160-bit word plus 3-bit index in, 19-bit slot out); it is the only sub-module.

Verification
REQ-031 FIFO empty at start -> no rden; done=1 three cycles after start; mv_count=0.
REQ-032 One word, slot1 = from 0o14 to 0o34, slot3 = from 0o06 to 0o25, other slots invalid, mv_ready always 1 -> exactly two moves in that order; mv_count=2; done=1.
REQ-033 Same word with mv_ready held low for 5 cycles on the first move -> mv_out stays at 0o14/0o34 for those 5 cycles; no extra rden; final mv_count=2.
REQ-034 Three words, all 24 slots valid -> exactly 3 rden pulses, 24 moves accepted in slot order, mv_count=24.
REQ-035 Reset pulsed while presenting slot 2 of a 2-word list -> all outputs 0 and state IDLE immediately; a new start drains the remaining FIFO contents.
REQ-036 32 words of all-valid slots (256 moves) -> mv_count saturates at 255; done=1.

Source files
------------

// File: rtl/chess_mv_pkg.sv
// Shared widths, move-slot field offsets and FSM encoding for the move unpacker.
package chess_mv_pkg;

    localparam int unsigned SLOT_W = 19;
    localparam int unsigned SLOT_N = 8;
    localparam int unsigned WORD_W = 160;
    localparam int unsigned IDX_W  = 4;
    localparam int unsigned SEL_W  = 3;
    localparam int unsigned CNT_W  = 8;

    localparam int unsigned INV_BIT = 18;
    localparam int unsigned FROM_HI = 11;
    localparam int unsigned FROM_LO = 6;
    localparam int unsigned TO_HI   = 5;
    localparam int unsigned TO_LO   = 0;

    localparam logic [IDX_W-1:0] IDX_FIRST = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(SLOT_N);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WAIT = 3'd2,
        ST_SCAN = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

    function automatic logic slot_valid(input logic [SLOT_W-1:0] s);
        return !s[INV_BIT];
    endfunction

endpackage

// File: rtl/mv_slot_sel.sv
// Picks one 19-bit move slot out of a 160-bit FIFO word; idx_i=0 selects slot1 (bits 151:133).
module mv_slot_sel
    import chess_mv_pkg::*;
(
    input  logic [WORD_W-1:0] word_i,
    input  logic [SEL_W-1:0]  idx_i,
    output logic [SLOT_W-1:0] slot_o
);

    // Top byte of the word carries no move data.
    logic unused_hi;
    assign unused_hi = ^word_i[WORD_W-1:SLOT_W*SLOT_N];

    always_comb begin
        slot_o = '0;
        for (int unsigned k = 0; k < SLOT_N; k++) begin
            if (idx_i == SEL_W'(k)) begin
                slot_o = word_i[SLOT_W*(SLOT_N-1-k) +: SLOT_W];
            end
        end
    end

endmodule

// File: rtl/move_unpacker.sv
// Drains 160-bit move-generator FIFO words and streams their valid 19-bit moves
// one at a time over a valid/ready handshake, counting accepted moves.
module move_unpacker
    import chess_mv_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [WORD_W-1:0] fifoOut,
    input  logic              fifoEmpty,
    output logic              rden,
    output logic [SLOT_W-1:0] mv_out,
    output logic              mv_valid,
    input  logic              mv_ready,
    output logic [CNT_W-1:0]  mv_count,
    output logic              done
);

    state_t              state_q;
    logic [WORD_W-1:0]   hold_q;
    logic [IDX_W-1:0]    idx_q;
    logic [SLOT_W-1:0]   mv_out_q;
    logic                mv_valid_q;
    logic [CNT_W-1:0]    mv_count_q;
    logic                done_q;

    logic [WORD_W-1:0]   sel_word_d;
    logic [SEL_W-1:0]    sel_idx_d;
    logic [SLOT_W-1:0]   sel_slot;
    logic                advance;

    // Selector always looks one slot ahead: slot1 of the incoming word in WAIT,
    // otherwise the slot after idx_q (idx_q is 1-based, selector is 0-based).
    always_comb begin
        sel_word_d = hold_q;
        sel_idx_d  = SEL_W'(idx_q);
        if (state_q == ST_WAIT) begin
            sel_word_d = fifoOut;
            sel_idx_d  = '0;
        end
    end

    mv_slot_sel u_slot_sel (
        .word_i (sel_word_d),
        .idx_i  (sel_idx_d),
        .slot_o (sel_slot)
    );

    assign rden     = (state_q == ST_REQ) && !fifoEmpty;
    assign advance  = !mv_valid_q || mv_ready;
    assign mv_out   = mv_out_q;
    assign mv_valid = mv_valid_q;
    assign mv_count = mv_count_q;
    assign done     = done_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            hold_q     <= '0;
            idx_q      <= IDX_FIRST;
            mv_out_q   <= '0;
            mv_valid_q <= 1'b0;
            mv_count_q <= '0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        mv_count_q <= '0;
                        done_q     <= 1'b0;
                        state_q    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    state_q <= fifoEmpty ? ST_FIN : ST_WAIT;
                end
                ST_WAIT: begin
                    hold_q     <= fifoOut;
                    idx_q      <= IDX_FIRST;
                    mv_out_q   <= sel_slot;
                    mv_valid_q <= slot_valid(sel_slot);
                    state_q    <= ST_SCAN;
                end
                ST_SCAN: begin
                    if (mv_valid_q && mv_ready && (mv_count_q != CNT_MAX)) begin
                        mv_count_q <= mv_count_q + CNT_W'(1);
                    end
                    if (advance) begin
                        if (idx_q == IDX_LAST) begin
                            mv_valid_q <= 1'b0;
                            state_q    <= ST_REQ;
                        end else begin
                            idx_q      <= idx_q + IDX_W'(1);
                            mv_out_q   <= sel_slot;
                            mv_valid_q <= slot_valid(sel_slot);
                        end
                    end
                end
                ST_FIN: begin
                    if (start) begin
                        mv_count_q <= '0;
                        done_q     <= 1'b0;
                        state_q    <= ST_REQ;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
